// File: rtl/voice_oscillator_if.sv
// Bundle of per-voice control inputs and sample outputs between the pitch
// front-end, the oscillator and the downstream mixer/envelope stage.
interface voice_oscillator_if #(
   parameter int OUT_WIDTH = 8
);
   logic                 i_sample_tick;
   logic                 i_delta_valid;
   logic [31:0]          i_phase_delta;
   logic                 i_gate;
   logic [1:0]           i_waveform;
   logic [7:0]           i_duty;
   logic [OUT_WIDTH-1:0] o_sample;
   logic                 o_sample_valid;
   logic [31:0]          o_phase;
   logic                 o_wrap;

   modport master (
      output i_sample_tick, i_delta_valid, i_phase_delta, i_gate, i_waveform, i_duty,
      input  o_sample, o_sample_valid, o_phase, o_wrap
   );

   modport slave (
      input  i_sample_tick, i_delta_valid, i_phase_delta, i_gate, i_waveform, i_duty,
      output o_sample, o_sample_valid, o_phase, o_wrap
   );
endinterface

// File: rtl/voice_oscillator.sv
// Phase-accumulator voice oscillator: saw, variable-duty square, triangle and
// LFSR noise, with gate-edge phase retrigger and mute while the gate is low.
module voice_oscillator #(
   parameter int OUT_WIDTH = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   voice_oscillator_if.slave bus
);

   function automatic logic [14:0] lfsr_step(input logic [14:0] s);
      lfsr_step = {s[13:0], s[14] ^ s[13]};
   endfunction

   logic [31:0]          r_delta;
   logic [31:0]          r_phase;
   logic                 r_gate_q;
   logic [14:0]          r_lfsr;
   logic                 r_vld_p1;
   logic                 r_carry_p1;
   logic                 r_vld_p2;
   logic                 r_wrap_p2;
   logic [OUT_WIDTH-1:0] r_sample_p2;

   logic [31:0]          w_d;
   logic [32:0]          w_sum;
   logic                 w_rise;
   logic [OUT_WIDTH-1:0] w_wave;

   // A delta presented alongside a tick takes effect for that very tick.
   assign w_d    = bus.i_delta_valid ? bus.i_phase_delta : r_delta;
   assign w_sum  = {1'b0, r_phase} + {1'b0, w_d};
   assign w_rise = bus.i_gate & ~r_gate_q;

   always_comb begin
      w_wave = '0;
      case (bus.i_waveform)
         2'd0:    w_wave = r_phase[31 -: OUT_WIDTH];
         2'd1:    w_wave = (r_phase[31:24] < bus.i_duty) ? '1 : '0;
         2'd2:    w_wave = r_phase[31] ? ~r_phase[30 -: OUT_WIDTH] : r_phase[30 -: OUT_WIDTH];
         default: w_wave = r_lfsr[OUT_WIDTH-1:0];
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_delta     <= '0;
         r_phase     <= '0;
         r_gate_q    <= 1'b0;
         r_lfsr      <= 15'h0001;
         r_vld_p1    <= 1'b0;
         r_carry_p1  <= 1'b0;
         r_vld_p2    <= 1'b0;
         r_wrap_p2   <= 1'b0;
         r_sample_p2 <= '0;
      end else begin
         // ---- stage 1: accumulate / retrigger ----
         r_gate_q <= bus.i_gate;
         r_vld_p1 <= bus.i_sample_tick;
         if (bus.i_delta_valid) begin
            r_delta <= bus.i_phase_delta;
         end
         if (bus.i_sample_tick) begin
            if (w_rise) begin
               r_phase    <= w_d;
               r_carry_p1 <= 1'b0;
            end else begin
               r_phase    <= w_sum[31:0];
               r_carry_p1 <= w_sum[32];
               // Noise rate follows pitch: one LFSR step per accumulator wrap.
               if (w_sum[32]) begin
                  r_lfsr <= lfsr_step(r_lfsr);
               end
            end
         end else if (w_rise) begin
            r_phase <= '0;
         end

         // ---- stage 2: waveform shaping and mute ----
         r_vld_p2  <= r_vld_p1;
         r_wrap_p2 <= r_vld_p1 & r_carry_p1;
         if (r_vld_p1) begin
            r_sample_p2 <= r_gate_q ? w_wave : '0;
         end
      end
   end

   assign bus.o_sample       = r_sample_p2;
   assign bus.o_sample_valid = r_vld_p2;
   assign bus.o_phase        = r_phase;
   assign bus.o_wrap         = r_wrap_p2;

endmodule

// File: tb/tb_voice_oscillator.sv
// Bench for voice_oscillator: point vectors from a table plus hand-written
// sweeps, with a tick-to-sample scoreboard checking value, wrap and latency.
module tb_voice_oscillator;

   typedef struct {
      logic [7:0] s;
      logic       w;
      int         c;
   } exp_t;

   typedef struct {
      logic [1:0]  wf;
      logic [7:0]  duty;
      logic [31:0] ph;
      logic [7:0]  exp_s;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t sb[$];
   vec_t vt[13];
   logic [7:0] ne[8];

   voice_oscillator_if #(.OUT_WIDTH(8)) bus();

   voice_oscillator #(.OUT_WIDTH(8)) dut (
      .i_clk (clk),
      .i_rst (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic drive(input logic tick, input logic dv, input logic [31:0] d, input logic g,
                        input logic push, input logic [7:0] es, input logic ew);
      exp_t e;
      bus.i_sample_tick = tick;
      bus.i_delta_valid = dv;
      bus.i_phase_delta = d;
      bus.i_gate        = g;
      if (tick && push) begin
         e.s = es;
         e.w = ew;
         e.c = cyc;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.i_sample_tick = 1'b0;
      bus.i_delta_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 32'h0, bus.i_gate, 1'b0, 8'h00, 1'b0);
   endtask

   // Scoreboard: every valid sample must match the oldest outstanding tick.
   always @(negedge clk) begin
      exp_t e;
      if (bus.o_sample_valid) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_valid: got valid=1 required none (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            chk("sample", 32'(bus.o_sample), 32'(e.s));
            chk("wrap", 32'(bus.o_wrap), 32'(e.w));
            chk("latency", 32'(cyc), 32'(e.c + 2));
         end
      end else if (bus.o_wrap) begin
         n_tests++;
         n_fail++;
         $display("FAIL wrap_without_valid: got wrap=1 required 0 (cycle %0d)", cyc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [7:0] top;
      logic [7:0] es;

      vt[0]  = '{2'd0, 8'h00, 32'h0000_0000, 8'h00};
      vt[1]  = '{2'd0, 8'h00, 32'h3F12_3456, 8'h3F};
      vt[2]  = '{2'd0, 8'h00, 32'hFFFF_FFFF, 8'hFF};
      vt[3]  = '{2'd1, 8'h80, 32'h7F00_0000, 8'hFF};
      vt[4]  = '{2'd1, 8'h80, 32'h8000_0000, 8'h00};
      vt[5]  = '{2'd1, 8'h00, 32'h0000_0000, 8'h00};
      vt[6]  = '{2'd1, 8'hFF, 32'hFE00_0000, 8'hFF};
      vt[7]  = '{2'd1, 8'hFF, 32'hFF00_0000, 8'h00};
      vt[8]  = '{2'd2, 8'h00, 32'h7F80_0000, 8'hFF};
      vt[9]  = '{2'd2, 8'h00, 32'h8000_0000, 8'hFF};
      vt[10] = '{2'd2, 8'h00, 32'hFF80_0000, 8'h00};
      vt[11] = '{2'd2, 8'h00, 32'h4000_0000, 8'h80};
      vt[12] = '{2'd2, 8'h00, 32'h0080_0000, 8'h01};
      ne = '{8'h01, 8'h02, 8'h02, 8'h04, 8'h04, 8'h08, 8'h08, 8'h10};

      // Reset must override tick, valid and gate.
      rst_n = 1'b0;
      bus.i_sample_tick = 1'b1;
      bus.i_delta_valid = 1'b1;
      bus.i_phase_delta = 32'h1234_5678;
      bus.i_gate        = 1'b1;
      bus.i_waveform    = 2'd0;
      bus.i_duty        = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_sample", 32'(bus.o_sample), 32'h0);
      chk("rst_valid", 32'(bus.o_sample_valid), 32'h0);
      chk("rst_phase", bus.o_phase, 32'h0);
      chk("rst_wrap", 32'(bus.o_wrap), 32'h0);
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("rst_phase_after", bus.o_phase, 32'h0);

      // Saw sweep with back-to-back ticks.
      drive(1'b0, 1'b1, 32'h0100_0000, 1'b1, 1'b0, 8'h00, 1'b0);
      for (int k = 1; k <= 300; k++)
         drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 8'(k), (k == 256));
      idle(4);

      // Gate low: muted but still accumulating.
      for (int k = 1; k <= 4; k++)
         drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 8'h00, 1'b0);
      idle(4);
      chk("mute_phase_adv", bus.o_phase, 32'h3000_0000);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 1'b0);
      chk("gate_rise_no_tick", bus.o_phase, 32'h0);

      // Square, duty 0x80 then duty 0.
      bus.i_waveform = 2'd1;
      bus.i_duty     = 8'h80;
      drive(1'b0, 1'b1, 32'h0200_0000, 1'b1, 1'b0, 8'h00, 1'b0);
      for (int k = 1; k <= 256; k++) begin
         top = 8'(2 * k);
         es  = (top < 8'h80) ? 8'hFF : 8'h00;
         drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, es, (k % 128 == 0));
      end
      idle(4);
      bus.i_duty = 8'h00;
      for (int k = 1; k <= 16; k++)
         drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 8'h00, 1'b0);
      idle(4);

      // Triangle full period.
      bus.i_waveform = 2'd2;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 1'b1, 32'h0080_0000, 1'b1, 1'b0, 8'h00, 1'b0);
      for (int k = 1; k <= 512; k++) begin
         es = (k < 256) ? 8'(k) : ((k < 512) ? 8'(511 - k) : 8'h00);
         drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, es, (k == 512));
      end
      idle(4);

      // Delta presented in the tick cycle wins over the stored delta.
      bus.i_waveform = 2'd0;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 1'b1, 32'h0100_0000, 1'b1, 1'b0, 8'h00, 1'b0);
      chk("retrigger_phase", bus.o_phase, 32'h0);
      drive(1'b1, 1'b1, 32'h0400_0000, 1'b1, 1'b1, 8'h04, 1'b0);
      chk("same_cycle_delta", bus.o_phase, 32'h0400_0000);
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 8'h08, 1'b0);
      chk("delta_reg_held", bus.o_phase, 32'h0800_0000);
      idle(4);

      // Gate rise coinciding with a tick.
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0);
      drive(1'b1, 1'b1, 32'h0000_0010, 1'b1, 1'b1, 8'h00, 1'b0);
      chk("gate_rise_tick", bus.o_phase, 32'h0000_0010);
      idle(4);

      // Point vectors: phase forced by a retrigger tick, shape checked.
      for (int i = 0; i < 13; i++) begin
         bus.i_waveform = vt[i].wf;
         bus.i_duty     = vt[i].duty;
         drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0);
         drive(1'b1, 1'b1, vt[i].ph, 1'b1, 1'b1, vt[i].exp_s, 1'b0);
         chk("vec_phase", bus.o_phase, vt[i].ph);
         idle(4);
      end

      // Noise from a fresh LFSR seed.
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bus.i_waveform = 2'd3;
      drive(1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 8'h00, 1'b0);
      for (int k = 0; k < 8; k++)
         drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, ne[k], (k % 2 == 1));
      idle(4);

      // Reset while a sample is in flight: it must vanish.
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("flight_rst_sample", 32'(bus.o_sample), 32'h0);
      chk("flight_rst_valid", 32'(bus.o_sample_valid), 32'h0);
      chk("flight_rst_phase", bus.o_phase, 32'h0);
      chk("flight_rst_wrap", 32'(bus.o_wrap), 32'h0);
      rst_n = 1'b1;
      idle(4);
      chk("post_rst_phase", bus.o_phase, 32'h0);

      for (int w = 0; w < 10 && sb.size() != 0; w++) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
